// File: rtl/glitch_trigger_sequencer.sv
// Purpose: waits for a synchronised TRIG_IN rising edge, waits DELAY cycles, fires one CUR_WIDTH-cycle glitch pulse, then holds off and steps the width.
// Latency: GLITCH_OUT rises DELAY+2 CLK edges after TRIG_IN is first captured; all outputs are registered.
// Backpressure: none; triggers outside WAIT_TRIG are dropped. Build option GLITCH_AUTO_REARM_EN re-arms straight from HOLDOFF.
module glitch_trigger_sequencer #(
    parameter int CNT_W      = 32,
    parameter int DELAY      = 100,
    parameter int WIDTH_MIN  = 5,
    parameter int WIDTH_MAX  = 40,
    parameter int WIDTH_STEP = 1,
    parameter int HOLDOFF    = 16000000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ARM,
    input  logic             TRIG_IN,
    output logic             GLITCH_OUT,
    output logic             BUSY,
    output logic             FIRED,
    output logic             WRAPPED,
    output logic [CNT_W-1:0] CUR_WIDTH,
    output logic [15:0]      ATTEMPTS
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_DELAY,
        ST_PULSE,
        ST_HOLDOFF
    } state_t;

    // Terminal counts; guarded so that DELAY=0 / HOLDOFF=1 never underflow.
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_PRE   = CNT_W'((HOLDOFF > 1) ? HOLDOFF - 2 : 0);
    localparam logic [CNT_W-1:0] W_MIN      = CNT_W'(WIDTH_MIN);
    localparam logic [CNT_W:0]   W_MAX_X    = (CNT_W+1)'(WIDTH_MAX);
    localparam logic [CNT_W:0]   W_STEP_X   = (CNT_W+1)'(WIDTH_STEP);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1, s2, s3;
    logic             trig_edge;
    logic             arm_ok;
    logic             delay_last;
    logic             pulse_last;
    logic             hold_last;
    logic [CNT_W:0]   width_next;
    logic             width_wrap;

    // s1 may go metastable on the asynchronous TRIG_IN; s2 is the first trusted copy, s3 delays it for edge detection.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= TRIG_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign trig_edge  = s2 & ~s3;
    assign delay_last = (cnt == DELAY_LAST);
    assign pulse_last = (cnt == (CUR_WIDTH - CNT_W'(1)));
    assign hold_last  = (cnt == HOLD_LAST);

    // One extra bit so a sweep near the top of the counter range cannot wrap silently.
    assign width_next = {1'b0, CUR_WIDTH} + W_STEP_X;
    assign width_wrap = (width_next > W_MAX_X);

`ifdef GLITCH_AUTO_REARM_EN
    assign arm_ok = ARM;
`else
    logic need_low;

    // After an attempt the host must drop ARM for a cycle before IDLE accepts another arm level.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            need_low <= 1'b0;
        end else if (!ARM) begin
            need_low <= 1'b0;
        end else if (state == ST_HOLDOFF && hold_last) begin
            need_low <= 1'b1;
        end
    end

    assign arm_ok = ARM & ~need_low;
`endif

    // Sequencer: state, shared cycle counter, width sweep and all registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            GLITCH_OUT <= 1'b0;
            BUSY       <= 1'b0;
            FIRED      <= 1'b0;
            WRAPPED    <= 1'b0;
            CUR_WIDTH  <= W_MIN;
            ATTEMPTS   <= '0;
        end else begin
            FIRED   <= 1'b0;
            WRAPPED <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm_ok) begin
                        state <= ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    // ARM has priority over a coincident trigger edge.
                    if (!ARM) begin
                        state <= ST_IDLE;
                    end else if (trig_edge) begin
                        cnt  <= '0;
                        BUSY <= 1'b1;
                        if (DELAY == 0) begin
                            state      <= ST_PULSE;
                            GLITCH_OUT <= 1'b1;
                        end else begin
                            state <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (!ARM) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (delay_last) begin
                        state      <= ST_PULSE;
                        cnt        <= '0;
                        GLITCH_OUT <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    // ARM and further triggers are ignored: a started pulse always completes.
                    if (pulse_last) begin
                        state      <= ST_HOLDOFF;
                        cnt        <= '0;
                        GLITCH_OUT <= 1'b0;
                        FIRED      <= (HOLDOFF == 1);
                        ATTEMPTS   <= ATTEMPTS + 16'd1;
                        if (width_wrap) begin
                            CUR_WIDTH <= W_MIN;
                            WRAPPED   <= 1'b1;
                        end else begin
                            CUR_WIDTH <= width_next[CNT_W-1:0];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_last) begin
                        BUSY <= 1'b0;
`ifdef GLITCH_AUTO_REARM_EN
                        state <= ARM ? ST_WAIT_TRIG : ST_IDLE;
`else
                        state <= ST_IDLE;
`endif
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        FIRED <= (cnt == HOLD_PRE);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_trigger_sequencer.sv
// Bench for glitch_trigger_sequencer: two instances (long delay / sweep-wrap config) driven one at a time.
// Expected pulse timing, widths, counters and strobes come from an event-level model of the rules.
// Stimulus is applied one time unit after the falling edge; outputs are sampled on the falling edge.
module tb_glitch_trigger_sequencer;

    localparam int A_D = 100, A_MIN = 5, A_MAX = 40, A_STEP = 1, A_H = 50;
    localparam int B_D = 0,   B_MIN = 3, B_MAX = 5,  B_STEP = 2, B_H = 4;

    logic CLK = 1'b0;
    logic RESET_N;
    logic arm, trig, sel;

    logic        glitch_a, busy_a, fired_a, wrapped_a;
    logic [31:0] cw_a;
    logic [15:0] att_a;
    logic        glitch_b, busy_b, fired_b, wrapped_b;
    logic [31:0] cw_b;
    logic [15:0] att_b;

    logic        g, busy, fired, wrapped;
    logic [31:0] cw;
    logic [15:0] att;

    int cfg_d[2], cfg_min[2], cfg_max[2], cfg_step[2], cfg_h[2];
    int exp_w[2], exp_att[2];

    int n_chk = 0, n_bad = 0;
    int cyc = 0;
    int rises = 0, falls = 0, fired_n = 0, wraps = 0;
    int rise_cyc = 0, fall_cyc = 0, fired_cyc = 0, wrap_cyc = 0;
    logic g_q = 1'b0;

    always #5 CLK = ~CLK;

    glitch_trigger_sequencer #(
        .CNT_W(32), .DELAY(A_D), .WIDTH_MIN(A_MIN), .WIDTH_MAX(A_MAX),
        .WIDTH_STEP(A_STEP), .HOLDOFF(A_H)
    ) dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .ARM(arm & ~sel), .TRIG_IN(trig & ~sel),
        .GLITCH_OUT(glitch_a), .BUSY(busy_a), .FIRED(fired_a), .WRAPPED(wrapped_a),
        .CUR_WIDTH(cw_a), .ATTEMPTS(att_a)
    );

    glitch_trigger_sequencer #(
        .CNT_W(32), .DELAY(B_D), .WIDTH_MIN(B_MIN), .WIDTH_MAX(B_MAX),
        .WIDTH_STEP(B_STEP), .HOLDOFF(B_H)
    ) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .ARM(arm & sel), .TRIG_IN(trig & sel),
        .GLITCH_OUT(glitch_b), .BUSY(busy_b), .FIRED(fired_b), .WRAPPED(wrapped_b),
        .CUR_WIDTH(cw_b), .ATTEMPTS(att_b)
    );

    assign g       = sel ? glitch_b  : glitch_a;
    assign busy    = sel ? busy_b    : busy_a;
    assign fired   = sel ? fired_b   : fired_a;
    assign wrapped = sel ? wrapped_b : wrapped_a;
    assign cw      = sel ? cw_b      : cw_a;
    assign att     = sel ? att_b     : att_a;

    always @(posedge CLK) cyc <= cyc + 1;

    // Event monitor: records the clock-edge index of every pulse edge and strobe of the selected instance.
    always @(negedge CLK) begin
        if (g && !g_q) begin rises++; rise_cyc = cyc; end
        if (!g && g_q) begin falls++; fall_cyc = cyc; end
        if (fired)     begin fired_n++; fired_cyc = cyc; end
        if (wrapped)   begin wraps++; wrap_cyc = cyc; end
        g_q = g;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return rises;
            1:       return falls;
            default: return fired_n;
        endcase
    endfunction

    task automatic wait_for(input int which, input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n <= limit && !ok; n++) begin
            if (cnt_of(which) != base) ok = 1'b1;
            else if (n < limit) tick(1);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            exp_w[s]   = cfg_min[s];
            exp_att[s] = 0;
        end
    endtask

    // One trigger attempt on the selected instance. abort_at>0 drops ARM that many cycles after edge k.
    task automatic attempt(input int abort_at, input bit drop_mid, input bit keep_arm, input bit extra);
        int  k, r0, f0, fd0, w0, rc, fc, nxt;
        bit  ok, wrap;
        arm = 1'b1;
        tick($urandom_range(3, 6));
        r0 = rises; f0 = falls; fd0 = fired_n; w0 = wraps;
        trig = 1'b1;
        k = cyc + 1;
        tick($urandom_range(2, 4));
        trig = 1'b0;
        if (abort_at != 0) begin
            while (cyc < k + abort_at) tick(1);
            arm = 1'b0;
            tick(cfg_d[sel] + 60);
            check("abort_no_pulse", rises, r0);
            check("abort_busy", busy, 0);
            check("abort_attempts", att, exp_att[sel]);
            return;
        end
        wait_for(0, r0, cfg_d[sel] + 20, ok);
        check("rise_seen", ok, 1);
        if (!ok) return;
        check("rise_time", rise_cyc, k + 2 + cfg_d[sel]);
        check("busy_in_pulse", busy, 1);
        rc = rise_cyc;
        if (extra) trig = 1'b1;
        tick(1);
        if (drop_mid) arm = 1'b0;
        tick(1);
        trig = 1'b0;
        wait_for(1, f0, 64, ok);
        check("fall_seen", ok, 1);
        if (!ok) return;
        check("width", fall_cyc - rc, exp_w[sel]);
        nxt  = exp_w[sel] + cfg_step[sel];
        wrap = (nxt > cfg_max[sel]);
        exp_w[sel]   = wrap ? cfg_min[sel] : nxt;
        exp_att[sel] = (exp_att[sel] + 1) % 65536;
        check("cur_width", cw, exp_w[sel]);
        check("attempts", att, exp_att[sel]);
        check("wrapped_cnt", wraps - w0, wrap);
        if (wrap) check("wrapped_time", wrap_cyc, fall_cyc);
        fc = fall_cyc;
        if (extra) begin
            trig = 1'b1;
            tick(2);
            trig = 1'b0;
        end
        wait_for(2, fd0, cfg_h[sel] + 10, ok);
        check("fired_seen", ok, 1);
        if (!ok) return;
        check("fired_time", fired_cyc, fc + cfg_h[sel] - 1);
        tick(3);
        check("fired_once", fired_n - fd0, 1);
        check("single_pulse", rises - r0, 1);
        check("busy_after", busy, 0);
        arm = keep_arm;
        tick(1);
    endtask

    initial begin
        int  r0, r;
        bit  ok;
        cfg_d    = '{A_D, B_D};
        cfg_min  = '{A_MIN, B_MIN};
        cfg_max  = '{A_MAX, B_MAX};
        cfg_step = '{A_STEP, B_STEP};
        cfg_h    = '{A_H, B_H};
        RESET_N = 1'b0; arm = 1'b0; trig = 1'b0; sel = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        tick(1);
        model_reset();

        // Reset values, then triggers with ARM low must never fire.
        check("rst_glitch", g, 0);
        check("rst_busy", busy, 0);
        check("rst_fired", fired, 0);
        check("rst_wrapped", wrapped, 0);
        check("rst_cur_width_a", cw_a, A_MIN);
        check("rst_cur_width_b", cw_b, B_MIN);
        check("rst_attempts", att, 0);
        r0 = rises;
        repeat (4) begin
            trig = 1'b1; tick($urandom_range(2, 5));
            trig = 1'b0; tick($urandom_range(2, 5));
        end
        tick(110);
        check("idle_no_pulse", rises, r0);
        check("idle_busy", busy, 0);

        // Directed: basic fire, abort 50 cycles into DELAY, ARM drop on pulse cycle 2.
        attempt(0, 1'b0, 1'b0, 1'b0);
        attempt(50, 1'b0, 1'b0, 1'b0);
        attempt(0, 1'b1, 1'b0, 1'b0);

        // Randomised mix; long enough to carry instance A through its 5..40 wrap.
        for (int i = 0; i < 48; i++) begin
            r = $urandom_range(0, 7);
            attempt((r == 0) ? $urandom_range(3, 95) : 0, r == 1, 1'b0, r >= 5);
        end

        // Asynchronous reset in the middle of a pulse.
        arm = 1'b1;
        tick(4);
        r0 = rises;
        trig = 1'b1; tick(3); trig = 1'b0;
        wait_for(0, r0, 130, ok);
        check("rst_rise_seen", ok, 1);
        tick(1);
        check("pre_rst_high", g, 1);
        #1 RESET_N = 1'b0;
        #1 check("async_drop", g, 0);
        tick(1);
        RESET_N = 1'b1;
        arm = 1'b0;
        tick(1);
        model_reset();
        check("post_rst_cur_width", cw, A_MIN);
        check("post_rst_attempts", att, 0);
        check("post_rst_busy", busy, 0);

        // Instance B: DELAY=0, widths 3,5,3 with a wrap, triggers during PULSE/HOLDOFF ignored.
        sel = 1'b1;
        tick(2);
        attempt(0, 1'b0, 1'b0, 1'b1);
        attempt(0, 1'b0, 1'b0, 1'b1);
        attempt(0, 1'b0, 1'b0, 1'b1);
        check("sweep_attempts", att, 3);

        // ARM held high through HOLDOFF.
        attempt(0, 1'b0, 1'b1, 1'b0);
`ifdef GLITCH_AUTO_REARM_EN
        attempt(0, 1'b0, 1'b0, 1'b0);
`else
        r0 = rises;
        trig = 1'b1; tick(2); trig = 1'b0;
        tick(20);
        check("no_rearm_on_level", rises, r0);
        arm = 1'b0;
        tick(1);
        attempt(0, 1'b0, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 3);
            attempt(0, r == 1, 1'b0, r >= 2);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
